spi_byte_engine: RTL

SPI master byte engine sitting directly downstream of the transaction FSM. It accepts one command/address/data byte at a time over a valid/ready handshake, shifts it out MSB-first on SPI mode 0 while shifting in a byte from MISO, and returns the received byte to the transaction FSM. Chip select stays low across consecutive bytes of one transaction and is released after a byte flagged `tx_last`.

---
 rtl/spi_pkg.sv | 13 +
 rtl/spi_byte_engine_clk_gen.sv | 38 +++
 rtl/spi_byte_engine.sv | 134 +++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the SPI byte engine.
package spi_pkg;
  localparam int unsigned CLK_DIV_DEF = 2;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;
endpackage

// File: rtl/spi_byte_engine_clk_gen.sv
// SCLK divider with single-cycle strobes marking the clk edge that toggles SCLK.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic rise_stb,
  output logic fall_stb
);
  localparam int unsigned CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          tick;

  assign tick     = en && (cnt == LAST);
  assign rise_stb = tick && !sclk;
  assign fall_stb = tick && sclk;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (tick) begin
      cnt  <= '0;
      sclk <= ~sclk;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/spi_byte_engine.sv
// SPI mode-0 master byte engine; CS held low across bytes until tx_last.
// SPI_RX_LATE_SAMPLE_EN moves MISO sampling to falling SCLK edges.
module spi_byte_engine
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  input  logic [BYTE_W-1:0] tx_data,
  input  logic              tx_last,
  output logic              tx_ready,
  input  logic              abort,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic              spi_cs_n
);
  localparam int unsigned CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] WLAST = CW'(CLK_DIV - 1);

  state_t            state;
  state_t            state_nx;
  logic [CW-1:0]     wcnt;
  logic [2:0]        bit_cnt;
  logic [BYTE_W-1:0] tx_sr;
  logic [BYTE_W-1:0] rx_sr;
  logic [BYTE_W-1:0] rx_next;
  logic              last_q;
  logic              accept;
  logic              kill;
  logic              wdone;
  logic              byte_end;
  logic              shift_en;
  logic              rise_stb;
  logic              fall_stb;
  logic              samp;

  assign tx_ready = (state == IDLE);
  assign accept   = tx_valid && tx_ready && !abort;
  assign kill     = abort && !(state == IDLE && spi_cs_n);
  assign wdone    = (wcnt == WLAST);
  assign byte_end = fall_stb && (bit_cnt == 3'd7);
  assign shift_en = (state == SHIFT) && !kill;
  assign busy     = (state != IDLE) || !spi_cs_n;

`ifdef SPI_RX_LATE_SAMPLE_EN
  assign samp    = fall_stb;
  assign rx_next = {rx_sr[BYTE_W-2:0], spi_miso};
`else
  assign samp    = rise_stb;
  assign rx_next = rx_sr;
`endif

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk      (clk),
    .rst      (rst),
    .en       (shift_en),
    .sclk     (spi_sclk),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  always_comb begin
    state_nx = state;
    if (kill) begin
      state_nx = GAP;
    end else begin
      unique case (state)
        IDLE:  if (accept) state_nx = spi_cs_n ? SETUP : SHIFT;
        SETUP: if (wdone) state_nx = SHIFT;
        SHIFT: if (byte_end) state_nx = last_q ? HOLD : IDLE;
        HOLD:  if (wdone) state_nx = GAP;
        GAP:   if (wdone) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      wcnt     <= '0;
      bit_cnt  <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      last_q   <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      spi_mosi <= 1'b0;
      spi_cs_n <= 1'b1;
    end else begin
      state    <= state_nx;
      rx_valid <= 1'b0;

      if (kill || state_nx != state) wcnt <= '0;
      else if (state inside {SETUP, HOLD, GAP}) wcnt <= wcnt + 1'b1;

      if (kill) spi_cs_n <= 1'b1;
      else if (accept) spi_cs_n <= 1'b0;
      else if (state == HOLD && wdone) spi_cs_n <= 1'b1;

      // A continuing byte enters SHIFT directly, so bit 7 goes out now.
      if (accept) begin
        tx_sr  <= tx_data;
        last_q <= tx_last;
        if (!spi_cs_n) spi_mosi <= tx_data[BYTE_W-1];
      end

      if (state == SETUP && wdone && !kill) spi_mosi <= tx_sr[BYTE_W-1];

      if (samp) rx_sr <= {rx_sr[BYTE_W-2:0], spi_miso};

      if (kill) begin
        bit_cnt <= '0;
      end else if (fall_stb) begin
        bit_cnt <= bit_cnt + 1'b1;
        if (bit_cnt != 3'd7) begin
          tx_sr    <= tx_sr << 1;
          spi_mosi <= tx_sr[BYTE_W-2];
        end else begin
          rx_valid <= 1'b1;
          rx_data  <= rx_next;
        end
      end
    end
  end
endmodule
